seg7_multi_scan: RTL and testbench

- Parametrised successor to the two-channel counter-to-7-segment display path.
- Snapshots CH counter values and renders each in hex or decimal. Decimal uses a sequential double-dabble FSM.
- Optional leading-zero blanking, overflow indication and a channel-separator decimal point.
- Multiplexes DIGITS active-low digits; sits between the counters and the board's CA..CG/DP/AN pins.

---
 rtl/seg7_multi_scan.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_seg7_multi_scan.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_scan.sv
// Multi-channel counter-to-7-segment display path: snapshots CH values, renders them in hex
// or decimal (sequential double-dabble) and time-multiplexes DIGITS active-low digits.
module seg7_multi_scan #(
    parameter int DIGITS      = 8,
    parameter int CH          = 2,
    parameter int VAL_W       = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*VAL_W-1:0]   cnt_val_i,
    input  logic                  load_i,
    input  logic                  mode_dec_i,
    input  logic                  blank_lz_i,
    output logic                  busy_o,
    output logic [CH-1:0]         ovf_o,
    output logic [6:0]            HEX_o,
    output logic                  DP_o,
    output logic [DIGITS-1:0]     AN_o
);

    localparam int DPC   = DIGITS / CH;
    localparam int DV_W  = 4 * DPC;
    localparam int BCD_W = 4 * DPC + 4;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int BIT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] DEC_LIMIT = pow10(DPC);

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DPC + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   busy_r;
    logic [CH-1:0]          ovf_r;
    logic [CH*VAL_W-1:0]    snap_val_r;
    logic                   snap_dec_r;
    logic                   snap_blank_r;
    logic [BCD_W-1:0]       bcd_r;
    logic [VAL_W-1:0]       shift_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [CH_W-1:0]        ch_cnt_r;
    logic [DV_W-1:0]        dec_res_r [CH];
    logic [6:0]             disp_r [DIGITS];
    logic [PRE_W-1:0]       presc_r;
    logic [IDX_W-1:0]       idx_r;
    logic [6:0]             hex_r;
    logic                   dp_r;
    logic [DIGITS-1:0]      an_r;

    logic [BCD_W-1:0]       adj_s;
    logic [BCD_W-1:0]       bcd_step_s;
    logic                   chan_done_s;
    logic                   last_step_s;
    logic [VAL_W-1:0]       next_val_s;
    logic [6:0]             frame_s [DIGITS];
    logic [CH-1:0]          ovf_s;
    logic [VAL_W-1:0]       cval_s;
    logic [DV_W-1:0]        digits_s;
    logic                   over_s;
    logic                   seen_s;
    logic [3:0]             nib_s;
    logic                   dp_s;
    logic [DIGITS-1:0]      an_s;

    assign adj_s       = dd_adjust(bcd_r);
    assign bcd_step_s  = (adj_s << 1) | BCD_W'(shift_r[VAL_W-1]);
    assign chan_done_s = (bit_cnt_r == BIT_W'(VAL_W - 1));
    assign last_step_s = chan_done_s && (ch_cnt_r == CH_W'(CH - 1));

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_i) begin
                    state_s = mode_dec_i ? ST_CONV : ST_COMMIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (last_step_s) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_CONV;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM state and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Value of the channel converted after the current one
    always_comb begin
        next_val_s = '0;
        for (int c = 0; c < CH; c++) begin
            if (c == int'(ch_cnt_r) + 1) begin
                next_val_s = snap_val_r[c*VAL_W +: VAL_W];
            end else begin
                next_val_s = next_val_s;
            end
        end
    end

    // Snapshot capture and sequential decimal conversion, one channel after another
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_val_r   <= '0;
            snap_dec_r   <= 1'b0;
            snap_blank_r <= 1'b0;
            bcd_r        <= '0;
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            ch_cnt_r     <= '0;
            for (int c = 0; c < CH; c++) begin
                dec_res_r[c] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_i) begin
                        snap_val_r   <= cnt_val_i;
                        snap_dec_r   <= mode_dec_i;
                        snap_blank_r <= blank_lz_i;
                        bcd_r        <= '0;
                        shift_r      <= cnt_val_i[VAL_W-1:0];
                        bit_cnt_r    <= '0;
                        ch_cnt_r     <= '0;
                    end
                end
                ST_CONV: begin
                    if (chan_done_s) begin
                        dec_res_r[ch_cnt_r] <= bcd_step_s[DV_W-1:0];
                        bcd_r               <= '0;
                        shift_r             <= next_val_s;
                        bit_cnt_r           <= '0;
                        ch_cnt_r            <= ch_cnt_r + 1'b1;
                    end else begin
                        bcd_r     <= bcd_step_s;
                        shift_r   <= shift_r << 1;
                        bit_cnt_r <= bit_cnt_r + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Render the committed frame: overflow dashes, leading-zero blanking, glyph lookup
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            frame_s[i] = 7'h7F;
        end
        ovf_s    = '0;
        cval_s   = '0;
        digits_s = '0;
        over_s   = 1'b0;
        seen_s   = 1'b0;
        nib_s    = 4'd0;
        for (int c = 0; c < CH; c++) begin
            cval_s   = snap_val_r[c*VAL_W +: VAL_W];
            digits_s = snap_dec_r ? dec_res_r[c] : DV_W'(cval_s);
            over_s   = snap_dec_r && (64'(cval_s) >= DEC_LIMIT);
            ovf_s[c] = over_s;
            seen_s   = 1'b0;
            for (int d = DPC - 1; d >= 0; d--) begin
                nib_s = digits_s[4*d +: 4];
                if (nib_s != 4'd0) begin
                    seen_s = 1'b1;
                end else begin
                    seen_s = seen_s;
                end
                if (over_s) begin
                    frame_s[c*DPC + d] = 7'h3F;
                end else if (snap_blank_r && !seen_s && (d != 0)) begin
                    frame_s[c*DPC + d] = 7'h7F;
                end else begin
                    frame_s[c*DPC + d] = glyph(nib_s);
                end
            end
        end
    end

    // Display buffer and overflow flags change together in the single commit cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp_r[i] <= 7'h40;
            end
            ovf_r <= '0;
        end else if (state_r == ST_COMMIT) begin
            disp_r <= frame_s;
            ovf_r  <= ovf_s;
        end
    end

    // Refresh prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (presc_r == PRE_W'(REFRESH_DIV - 1)) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + 1'b1;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    // Anode select and channel-separator decimal point for the current index
    always_comb begin
        dp_s = 1'b1;
        an_s = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                an_s[i] = 1'b0;
            end else begin
                an_s[i] = 1'b1;
            end
        end
        for (int c = 1; c < CH; c++) begin
            if (idx_r == IDX_W'(c * DPC)) begin
                dp_s = 1'b0;
            end else begin
                dp_s = dp_s;
            end
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_r <= 7'h7F;
            dp_r  <= 1'b1;
            an_r  <= '1;
        end else begin
            hex_r <= disp_r[idx_r];
            dp_r  <= dp_s;
            an_r  <= an_s;
        end
    end

    assign busy_o = busy_r;
    assign ovf_o  = ovf_r;
    assign HEX_o  = hex_r;
    assign DP_o   = dp_r;
    assign AN_o   = an_r;

endmodule

// File: tb/tb_seg7_multi_scan.sv
// Scoreboard bench for seg7_multi_scan: loads push expected frames, a monitor checks every
// displayed digit against the committed frame and checks busy length and overflow at each commit.
module tb_seg7_multi_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cnt_val;
    logic        load;
    logic        mode_dec;
    logic        blank_lz;
    logic        busy;
    logic [1:0]  ovf;
    logic [6:0]  hex;
    logic        dp;
    logic [7:0]  an;

    typedef struct packed {
        logic [55:0] glyphs;
        logic [1:0]  ovf;
        logic [7:0]  busy_len;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_mis = 0;
    logic        armed = 1'b0;
    logic [55:0] model = {8{7'h40}};

    seg7_multi_scan #(.DIGITS(8), .CH(2), .VAL_W(16), .REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .cnt_val_i(cnt_val), .load_i(load), .mode_dec_i(mode_dec),
        .blank_lz_i(blank_lz), .busy_o(busy), .ovf_o(ovf), .HEX_o(hex), .DP_o(dp), .AN_o(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle digit check against the committed frame, commit check on busy fall
    initial begin : monitor
        logic       prev_busy;
        logic       prev_rst;
        int         busy_cnt;
        int         idx;
        logic [7:0] pat;
        exp_t       e;
        prev_busy = 1'b0;
        prev_rst  = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (armed) begin
                idx = -1;
                for (int i = 0; i < 8; i++) begin
                    pat = ~(8'b1 << i);
                    if (an === pat) idx = i;
                end
                if (idx >= 0) begin
                    check("digit_glyph", hex, model[idx*7 +: 7]);
                    check("digit_dp", dp, (idx == 4) ? 1'b0 : 1'b1);
                end else if (an !== 8'hFF) begin
                    check("an_onehot", an, 8'hFF);
                end
                if (busy) busy_cnt++;
                if (prev_busy && !busy && !prev_rst) begin
                    if (sb.size() == 0) begin
                        check("unexpected_commit", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("commit_ovf", ovf, e.ovf);
                        check("busy_len", busy_cnt, e.busy_len);
                        model = e.glyphs;
                    end
                    busy_cnt = 0;
                end
                if (rst) begin
                    model    = {8{7'h40}};
                    busy_cnt = 0;
                end
                prev_busy = busy;
                prev_rst  = rst;
            end
        end
    end

    task automatic do_load(input logic [15:0] c0, input logic [15:0] c1, input logic dec,
                           input logic blank, input int hold, input logic push,
                           input logic [55:0] glyphs, input logic [1:0] eovf, input logic [7:0] blen);
        exp_t e;
        @(posedge clk);
        #1;
        cnt_val  = {c1, c0};
        mode_dec = dec;
        blank_lz = blank;
        load     = 1'b1;
        if (push) begin
            e.glyphs   = glyphs;
            e.ovf      = eovf;
            e.busy_len = blen;
            sb.push_back(e);
        end
        repeat (hold) @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("commit_timeout", sb.size(), 0);
        sb.delete();
        repeat (40) @(posedge clk);
    endtask

    initial begin
        logic [7:0] an_exp;
        rst = 1'b1; load = 1'b0; cnt_val = '0; mode_dec = 1'b0; blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state, then scan stepping and wrap
        @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_hex", hex, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 2'b00);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            an_exp = ~(8'b1 << ((j / 4) % 8));
            check("scan_an", an, an_exp);
            check("scan_hex", hex, 7'h40);
            check("scan_dp", dp, (an_exp == 8'hEF) ? 1'b0 : 1'b1);
        end
        armed = 1'b1;

        // hex, load held into the commit cycle (second pulse must be ignored)
        do_load(16'h1A07, 16'h0000, 1'b0, 1'b0, 2, 1'b1,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h08, 7'h40, 7'h78}, 2'b00, 8'd1);
        wait_done();
        do_load(16'hBCDE, 16'h8623, 1'b0, 1'b0, 1, 1'b1,
                {7'h00, 7'h02, 7'h24, 7'h30, 7'h03, 7'h46, 7'h21, 7'h06}, 2'b00, 8'd1);
        wait_done();
        // decimal boundaries
        do_load(16'd9999, 16'd42, 1'b1, 1'b1, 1, 1'b1,
                {7'h7F, 7'h7F, 7'h19, 7'h24, 7'h10, 7'h10, 7'h10, 7'h10}, 2'b00, 8'd33);
        wait_done();
        do_load(16'd10000, 16'd0, 1'b1, 1'b1, 1, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 2'b01, 8'd33);
        wait_done();

        // reset mid-conversion: no commit, everything back to reset state
        do_load(16'd777, 16'd65000, 1'b1, 1'b0, 1, 1'b0, '0, 2'b00, 8'd0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_ovf", ovf, 2'b00);
        repeat (60) @(posedge clk);

        // decimal, second load at k+10 with new bus values must be ignored
        do_load(16'd1234, 16'd56, 1'b1, 1'b0, 1, 1'b1,
                {7'h40, 7'h40, 7'h12, 7'h02, 7'h79, 7'h24, 7'h30, 7'h19}, 2'b00, 8'd33);
        repeat (9) @(posedge clk);
        #1;
        cnt_val = {16'd5, 16'd9876};
        load    = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_done();

        do_load(16'd65535, 16'd9, 1'b1, 1'b0, 1, 1'b1,
                {7'h40, 7'h40, 7'h40, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 2'b01, 8'd33);
        wait_done();
        do_load(16'd5, 16'd12345, 1'b1, 1'b1, 1, 1'b1,
                {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h12}, 2'b10, 8'd33);
        wait_done();

        // hex with blanking, back-to-back frames
        do_load(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 2'b00, 8'd1);
        wait_done();
        do_load(16'h0000, 16'h0030, 1'b0, 1'b1, 1, 1'b1,
                {7'h7F, 7'h7F, 7'h30, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 2'b00, 8'd1);
        wait_done();

        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
